// File: rtl/fetch_arbiter.sv
// Round-robin arbiter granting three tile requesters access to one fetch engine.
// Handles grant timeouts and deferred address-pointer flushes.
module fetch_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       flush,
    input  logic       fetch_done,
    output logic       start_fetch,
    output logic [1:0] buffer_select,
    output logic       reset_addr_counters,
    output logic [2:0] grant,
    output logic [2:0] done,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        CLEAR = 2'b11
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          pend;
    logic          pend_nx;
    logic [1:0]    last;
    logic [1:0]    last_nx;
    logic [2:0]    grant_nx;
    logic [1:0]    sel_nx;
    logic [2:0]    done_nx;
    logic          timeout_nx;
    logic [1:0]    win;

    // Search starts one past the last completed requester.
    always_comb begin
        win = 2'd0;
        unique case (last)
            2'd0: begin
                if (req[1])      win = 2'd1;
                else if (req[2]) win = 2'd2;
                else             win = 2'd0;
            end
            2'd1: begin
                if (req[2])      win = 2'd2;
                else if (req[0]) win = 2'd0;
                else             win = 2'd1;
            end
            default: begin
                if (req[0])      win = 2'd0;
                else if (req[1]) win = 2'd1;
                else             win = 2'd2;
            end
        endcase
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        pend_nx    = pend;
        last_nx    = last;
        grant_nx   = grant;
        sel_nx     = buffer_select;
        done_nx    = 3'b000;
        timeout_nx = 1'b0;
        unique case (state)
            IDLE: begin
                if (pend || flush) begin
                    pend_nx  = 1'b0;
                    state_nx = CLEAR;
                end else if (req != 3'b000) begin
                    grant_nx = 3'b001 << win;
                    sel_nx   = win;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                pend_nx  = pend | flush;
                cnt_nx   = '0;
                state_nx = WAIT;
            end
            WAIT: begin
                pend_nx = pend | flush;
                // Completion wins over a timeout landing in the same cycle.
                if (fetch_done) begin
                    done_nx  = grant;
                    last_nx  = buffer_select;
                    grant_nx = 3'b000;
                    state_nx = IDLE;
                end else if (cnt == CNT_LAST) begin
                    timeout_nx = 1'b1;
                    grant_nx   = 3'b000;
                    state_nx   = IDLE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            CLEAR: begin
                pend_nx  = flush;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            pend          <= 1'b0;
            last          <= 2'd2;
            grant         <= 3'b000;
            buffer_select <= 2'b00;
            done          <= 3'b000;
            timeout       <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            pend          <= pend_nx;
            last          <= last_nx;
            grant         <= grant_nx;
            buffer_select <= sel_nx;
            done          <= done_nx;
            timeout       <= timeout_nx;
        end
    end

    assign start_fetch         = (state == ISSUE);
    assign reset_addr_counters = (state == CLEAR);
    assign busy                = (state != IDLE);

    a_pulse_excl: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(start_fetch && reset_addr_counters)
    );

endmodule

// File: tb/tb_fetch_arbiter.sv
// Bench for fetch_arbiter: per-cycle reference model plus directed scenarios
// covering arbitration order, timeout, flush deferral, races and reset.
module tb_fetch_arbiter;

    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req = 3'b000;
    logic       flush = 1'b0;
    logic       fetch_done = 1'b0;
    logic       start_fetch;
    logic [1:0] buffer_select;
    logic       reset_addr_counters;
    logic [2:0] grant;
    logic [2:0] done;
    logic       busy;
    logic       timeout;

    fetch_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req                 (req),
        .flush               (flush),
        .fetch_done          (fetch_done),
        .start_fetch         (start_fetch),
        .buffer_select       (buffer_select),
        .reset_addr_counters (reset_addr_counters),
        .grant               (grant),
        .done                (done),
        .busy                (busy),
        .timeout             (timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: owner is the served index (-1 none); age counts cycles since the grant.
    int         m_owner = -1;
    int         m_age = 0;
    int         m_last = 2;
    bit         m_clr = 1'b0;
    bit         m_owed = 1'b0;
    logic [1:0] m_sel = 2'b00;
    logic [2:0] m_done = 3'b000;
    bit         m_to = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        logic [2:0] nd;
        bit         nt;
        int         idx;
        if (!rst_n) begin
            m_owner = -1;
            m_age   = 0;
            m_last  = 2;
            m_clr   = 1'b0;
            m_owed  = 1'b0;
            m_sel   = 2'b00;
            m_done  = 3'b000;
            m_to    = 1'b0;
        end else begin
            nd = 3'b000;
            nt = 1'b0;
            if (m_clr) begin
                m_clr  = 1'b0;
                m_owed = flush;
            end else if (m_owner < 0) begin
                if (m_owed || flush) begin
                    m_clr  = 1'b1;
                    m_owed = 1'b0;
                end else if (req != 3'b000) begin
                    for (int k = 1; k <= 3; k++) begin
                        idx = (m_last + k) % 3;
                        if (req[idx] && m_owner < 0) m_owner = idx;
                    end
                    m_sel = 2'(m_owner);
                    m_age = 0;
                end
            end else begin
                if (flush) m_owed = 1'b1;
                if (m_age == 0) begin
                    m_age = 1;
                end else if (fetch_done) begin
                    nd      = 3'(1 << m_owner);
                    m_last  = m_owner;
                    m_owner = -1;
                end else if (m_age == T) begin
                    nt      = 1'b1;
                    m_owner = -1;
                end else begin
                    m_age++;
                end
            end
            m_done = nd;
            m_to   = nt;
        end
    end

    always @(negedge clk) begin : compare
        logic [11:0] expv;
        logic [11:0] actv;
        logic [2:0]  eg;
        eg = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
        expv = {(m_owner >= 0 && m_age == 0), m_clr, m_sel, eg,
                m_done, (m_owner >= 0 || m_clr), m_to};
        actv = {start_fetch, reset_addr_counters, buffer_select, grant,
                done, busy, timeout};
        n_cmp++;
        if (actv !== expv) begin
            n_bad++;
            $display("FAIL model t=%0t actual=%b required=%b", $time, actv, expv);
        end
    end

    task automatic chk(input string nm, input logic [11:0] act,
                       input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (start_fetch) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(nm, 12'(ok), 12'(1));
    endtask

    function automatic logic [11:0] outs();
        return {start_fetch, reset_addr_counters, buffer_select, grant,
                done, busy, timeout};
    endfunction

    logic [2:0] rr_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [1:0] rr_s [4] = '{2'b00, 2'b01, 2'b10, 2'b00};

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stim
        int  n;
        int  pulses;
        bit  found;

        repeat (2) tick();
        chk("reset_outs", outs(), 12'h000);
        rst_n = 1'b1;
        tick();

        // Single requester
        req = 3'b001;
        wait_start("t1_start");
        chk("t1_sel", 12'(buffer_select), 12'(2'b00));
        chk("t1_grant", 12'(grant), 12'(3'b001));
        repeat (3) tick();
        fetch_done = 1'b1;
        tick();
        fetch_done = 1'b0;
        req = 3'b000;
        chk("t1_done", 12'(done), 12'(3'b001));
        tick();
        chk("t1_after", 12'({grant, busy, done}), 12'h000);

        // Round robin with all three held
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            wait_start("t2_start");
            chk("t2_grant", 12'(grant), 12'(rr_g[i]));
            chk("t2_sel", 12'(buffer_select), 12'(rr_s[i]));
            repeat (2) tick();
            fetch_done = 1'b1;
            tick();
            fetch_done = 1'b0;
            chk("t2_done", 12'(done), 12'(rr_g[i]));
        end
        req = 3'b000;
        repeat (2) tick();

        // Timeout, then re-grant of the same requester
        req = 3'b010;
        wait_start("t3_start");
        chk("t3_grant", 12'(grant), 12'(3'b010));
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (timeout) begin
                found = 1'b1;
                break;
            end
        end
        chk("t3_seen", 12'(found), 12'(1));
        chk("t3_delay", 12'(n - 1), 12'(8));
        chk("t3_gr_done", 12'({grant, done}), 12'h000);
        wait_start("t3_restart");
        chk("t3_regrant", 12'(grant), 12'(3'b010));

        // fetch_done on the final timeout cycle counts as completion
        repeat (8) tick();
        fetch_done = 1'b1;
        tick();
        fetch_done = 1'b0;
        req = 3'b000;
        chk("t3_race_done", 12'(done), 12'(3'b010));
        chk("t3_race_to", 12'(timeout), 12'(0));
        tick();

        // Stray completion while idle
        fetch_done = 1'b1;
        tick();
        fetch_done = 1'b0;
        chk("stray_outs", outs() & 12'hCFF, 12'h000);
        tick();

        // Two flushes during WAIT collapse into one deferred clear
        req = 3'b011;
        wait_start("t4_start");
        chk("t4_grant", 12'(grant), 12'(3'b001));
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        fetch_done = 1'b1;
        tick();
        fetch_done = 1'b0;
        req = 3'b010;
        chk("t4_done", 12'(done), 12'(3'b001));
        pulses = 0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (start_fetch) begin
                found = 1'b1;
                break;
            end
            if (reset_addr_counters) pulses++;
            tick();
        end
        chk("t4_restart", 12'(found), 12'(1));
        chk("t4_clears", 12'(pulses), 12'(1));
        chk("t4_grant2", 12'(grant), 12'(3'b010));
        tick();
        fetch_done = 1'b1;
        tick();
        fetch_done = 1'b0;
        req = 3'b000;
        chk("t4_done2", 12'(done), 12'(3'b010));
        tick();

        // Reset in the middle of WAIT
        req = 3'b001;
        wait_start("t5_start");
        repeat (2) tick();
        rst_n = 1'b0;
        req = 3'b100;
        #1;
        chk("t5_rst_outs", outs(), 12'h000);
        tick();
        chk("t5_rst_hold", outs(), 12'h000);
        rst_n = 1'b1;
        wait_start("t5_restart");
        chk("t5_sel", 12'(buffer_select), 12'(2'b10));
        chk("t5_grant", 12'(grant), 12'(3'b100));
        tick();
        fetch_done = 1'b1;
        tick();
        fetch_done = 1'b0;
        req = 3'b000;
        chk("t5_done", 12'(done), 12'(3'b100));
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_arbiter.md
FETCH_ARBITER -- requirements
Module: fetch_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, SHALL set the maximum number of cycles spent waiting for fetch_done per grant (legal range 2..65535).
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 req  input  3  SHALL carry level requests; bit0 = Weights, bit1 = K-Matrix, bit2 = V-Matrix; each is held high until the matching done pulse.
REQ-005 flush  input  1  SHALL be a one-cycle pulse requesting a reset of the fetch engine's address pointers.
REQ-006 fetch_done  input  1  SHALL be the fetch engine's one-cycle completion pulse.
REQ-007 start_fetch  output  1  SHALL be the one-cycle fetch start pulse to the fetch engine.
REQ-008 buffer_select  output  2  SHALL carry the buffer code to the fetch engine: 00 Weights, 01 K, 10 V.
REQ-009 reset_addr_counters  output  1  SHALL be the one-cycle pointer-reset pulse to the fetch engine.
REQ-010 grant  output  3  SHALL be a one-hot indication of the requester currently being served, or all zeros.
REQ-011 done  output  3  SHALL pulse one cycle on the bit of the requester whose tile fetch completed.
REQ-012 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-013 timeout  output  1  SHALL pulse one cycle when a grant is abandoned because no fetch_done arrived.

Function
REQ-014 States SHALL be IDLE, ISSUE, WAIT and CLEAR, encoded in 2 bits.
REQ-015 IDLE transitions:
- If a flush is pending, go to CLEAR; flush SHALL take priority over req.
- Else if req != 0, latch the round-robin winner into grant and buffer_select, then go to ISSUE.
- Else stay in IDLE.
REQ-016 Round-robin order SHALL begin at the index after last_served (mod 3); last_served SHALL update only when done pulses.
REQ-017 ISSUE SHALL assert start_fetch for exactly one cycle, then go unconditionally to WAIT.
REQ-018 WAIT SHALL increment a wait counter each cycle.
- On fetch_done: go to IDLE; done[winner] asserts in the following cycle (registered); last_served is set to the winner.
- If the counter reaches TIMEOUT_CYCLES-1 without fetch_done: pulse timeout, clear grant, go to IDLE, and leave last_served unchanged.
REQ-019 The wait counter SHALL clear on every entry to WAIT and SHALL be ceil(log2(TIMEOUT_CYCLES)) bits wide.
REQ-020 fetch_done arriving in the same cycle the timeout is reached SHALL be treated as completion; timeout SHALL NOT pulse.
REQ-021 buffer_select SHALL remain stable from ISSUE through the fetch_done cycle, so the engine increments the correct pointer.
REQ-022 grant SHALL be asserted from ISSUE through WAIT and SHALL clear in the cycle after leaving WAIT.
REQ-023 CLEAR SHALL assert reset_addr_counters for exactly one cycle and clear the pending-flush flag, then go to IDLE.
REQ-024 A flush arriving in any state other than IDLE SHALL set the pending-flush flag. Multiple flushes while pending SHALL collapse into one CLEAR.
REQ-025 fetch_done received outside WAIT SHALL be ignored, with no done pulse and no state change.
REQ-026 A req bit dropping during ISSUE or WAIT SHALL NOT abort the grant.
REQ-027 start_fetch, reset_addr_counters and busy SHALL be decoded from the state register only, with no combinational path from any input.
REQ-028 At most one of start_fetch and reset_addr_counters SHALL be high in any cycle.

Reset
REQ-029 While rst_n = 0, the following SHALL hold:
- state = IDLE
- start_fetch = 0, reset_addr_counters = 0
- buffer_select = 00
- grant = 000, done = 000
- busy = 0, timeout = 0
- wait counter = 0, pending-flush = 0
- last_served = 2, so req0 has first priority after reset.
REQ-030 Reset asserted mid-WAIT SHALL abandon the grant with no done or timeout pulse; the first request after release SHALL restart arbitration from req0 priority.

Verification
REQ-031 Single request: req=001, fetch_done 3 cycles after start_fetch -> start_fetch one cycle with buffer_select=00; done=001 one cycle after fetch_done; grant=000 and busy=0 afterwards.
REQ-032 Round-robin: req=111 held, fetch_done returned 2 cycles after each start_fetch -> grant sequence 001, 010, 100, 001, and buffer_select 00, 01, 10, 00.
REQ-033 Timeout: TIMEOUT_CYCLES=8, req=010, no fetch_done -> timeout pulses 8 cycles after entering WAIT, with no done; the next grant is again 010.
REQ-034 Flush during WAIT: flush pulsed twice while req0 is served, req=011 -> after done=001, one reset_addr_counters pulse occurs before the next start_fetch, and the next grant is 010.
REQ-035 Races: fetch_done coincides with the last timeout cycle -> done pulses and timeout stays 0. Stray fetch_done in IDLE -> no output change.
REQ-036 Reset mid-WAIT, then release with req=100 -> all outputs 0 during reset; the first start_fetch after release has buffer_select=10.
